ni_param: RTL and testbench

NI_PARAM -- requirements
Module: ni_param

---
 rtl/ni_param.sv | 142 ++++++++++++++
 tb/tb_ni_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ni_param.sv
// Network interface between a GPU endpoint and a router port.
// TX: GPU flits with a valid destination ID are rewritten to a routing
// address and buffered toward the router. RX: router flits addressed to
// this endpoint are rewritten back to a GPU ID and buffered toward the GPU.
// Flits that fail classification are discarded and counted (saturating).

// One direction: FIFO_DEPTH-entry circular buffer plus a registered output stage.
module ni_chan #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              push,
  output logic              full,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic              wr, rd;

  assign full = (cnt == (AW+1)'(DEPTH));
  assign wr   = push && !full;
  // Head moves into the output stage when the stage is free or draining now.
  assign rd   = (cnt != '0) && (!out_valid || out_ready);

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= in_data;
  end

  // Pointers wrap naturally at AW bits; count tracks push minus pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Output stage holds data and valid steady until the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (rd) begin
      out_valid <= 1'b1;
      out_data  <= mem[rptr];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

module ni_param #(
  parameter int GPU_ID      = 11,
  parameter int DATA_W      = 16,
  parameter int HEADER_W    = 6,
  parameter int FIFO_DEPTH  = 8,
  parameter int NUM_GPU     = 32,
  parameter int ADDR_OFFSET = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] gpu_data_in,
  input  logic              gpu_valid_in,
  output logic              gpu_ready_out,
  output logic [DATA_W-1:0] gpu_data_out,
  output logic              gpu_valid_out,
  input  logic              gpu_ready_in,
  output logic [DATA_W-1:0] router_data_out,
  output logic              router_valid_out,
  input  logic              router_ready_in,
  input  logic [DATA_W-1:0] router_data_in,
  input  logic              router_valid_in,
  output logic              router_ready_out,
  output logic [CNT_W-1:0]  drop_cnt_tx,
  output logic [CNT_W-1:0]  drop_cnt_rx
);
  localparam int PL_W = DATA_W - HEADER_W;
  localparam logic [HEADER_W-1:0] OFS     = HEADER_W'(ADDR_OFFSET);
  localparam logic [HEADER_W-1:0] MY_ADDR = HEADER_W'(GPU_ID + ADDR_OFFSET);

  logic [HEADER_W-1:0] tx_hdr, rx_hdr;
  logic [DATA_W-1:0]   tx_data, rx_data;
  logic                tx_ok, rx_ok, tx_full, rx_full, tx_drop, rx_drop;

  assign tx_hdr  = gpu_data_in[DATA_W-1 -: HEADER_W];
  assign tx_ok   = (tx_hdr != '0) && (int'(tx_hdr) <= NUM_GPU);
  assign tx_data = {tx_hdr + OFS, gpu_data_in[PL_W-1:0]};

  assign rx_hdr  = router_data_in[DATA_W-1 -: HEADER_W];
  assign rx_ok   = (rx_hdr == MY_ADDR);
  assign rx_data = {rx_hdr - OFS, router_data_in[PL_W-1:0]};

  // Ready reflects registered occupancy only. Misaddressed flits are
  // consumed on sight, even with a full FIFO, since they need no space.
  assign gpu_ready_out    = !tx_full;
  assign router_ready_out = !rx_full;
  assign tx_drop = gpu_valid_in && !tx_ok;
  assign rx_drop = router_valid_in && !rx_ok;

  ni_chan #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .reset_n(reset_n),
    .in_data(tx_data), .push(gpu_valid_in && tx_ok), .full(tx_full),
    .out_data(router_data_out), .out_valid(router_valid_out),
    .out_ready(router_ready_in)
  );

  ni_chan #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .reset_n(reset_n),
    .in_data(rx_data), .push(router_valid_in && rx_ok), .full(rx_full),
    .out_data(gpu_data_out), .out_valid(gpu_valid_out),
    .out_ready(gpu_ready_in)
  );

  // Saturating drop counters, one per direction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_tx <= '0;
      drop_cnt_rx <= '0;
    end else begin
      if (tx_drop && drop_cnt_tx != '1) drop_cnt_tx <= drop_cnt_tx + 1'b1;
      if (rx_drop && drop_cnt_rx != '1) drop_cnt_rx <= drop_cnt_rx + 1'b1;
    end
  end
endmodule

// File: tb/tb_ni_param.sv
// Randomized + directed bench for ni_param against a queue-based model.
module tb_ni_param;
  localparam int DW = 16, HW = 6, DEPTH = 8, NG = 32, OFS = 3, ID = 11, CW = 8;

  logic clk = 0, reset_n = 0;
  logic [DW-1:0] gpu_data_in = '0, router_data_in = '0;
  logic gpu_valid_in = 0, router_valid_in = 0, gpu_ready_in = 0, router_ready_in = 0;
  logic gpu_ready_out, router_ready_out, gpu_valid_out, router_valid_out;
  logic [DW-1:0] gpu_data_out, router_data_out;
  logic [CW-1:0] drop_cnt_tx, drop_cnt_rx;

  int checks = 0, failures = 0;

  ni_param #(.GPU_ID(ID), .DATA_W(DW), .HEADER_W(HW), .FIFO_DEPTH(DEPTH),
             .NUM_GPU(NG), .ADDR_OFFSET(OFS), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .gpu_data_in(gpu_data_in), .gpu_valid_in(gpu_valid_in), .gpu_ready_out(gpu_ready_out),
    .gpu_data_out(gpu_data_out), .gpu_valid_out(gpu_valid_out), .gpu_ready_in(gpu_ready_in),
    .router_data_out(router_data_out), .router_valid_out(router_valid_out),
    .router_ready_in(router_ready_in), .router_data_in(router_data_in),
    .router_valid_in(router_valid_in), .router_ready_out(router_ready_out),
    .drop_cnt_tx(drop_cnt_tx), .drop_cnt_rx(drop_cnt_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each direction: queue of buffered flits (capacity DEPTH) plus one shown flit.
  logic [DW-1:0] txq[$], rxq[$];
  bit tx_show, rx_show;
  logic [DW-1:0] tx_sd, rx_sd;
  int m_drop_tx, m_drop_rx;
  bit tx_taken, rx_taken;

  function automatic bit tx_valid_id(input logic [DW-1:0] d);
    int h = int'(d[DW-1 -: HW]);
    return (h >= 1) && (h <= NG);
  endfunction

  function automatic logic [DW-1:0] rewrite(input logic [DW-1:0] d, input int delta);
    int h = (int'(d[DW-1 -: HW]) + delta) % 64;
    if (h < 0) h += 64;
    return (DW'(h) << (DW - HW)) | (d & DW'((1 << (DW - HW)) - 1));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txq.delete(); rxq.delete();
      tx_show = 0; rx_show = 0; tx_sd = '0; rx_sd = '0;
      m_drop_tx = 0; m_drop_rx = 0; tx_taken = 0; rx_taken = 0;
    end else begin
      bit tx_fire, rx_fire, tx_full, rx_full;
      tx_fire = tx_show && router_ready_in;
      rx_fire = rx_show && gpu_ready_in;
      tx_full = (txq.size() >= DEPTH);
      rx_full = (rxq.size() >= DEPTH);
      if (txq.size() > 0 && (!tx_show || tx_fire)) begin tx_show = 1; tx_sd = txq.pop_front(); end
      else if (tx_fire) tx_show = 0;
      if (rxq.size() > 0 && (!rx_show || rx_fire)) begin rx_show = 1; rx_sd = rxq.pop_front(); end
      else if (rx_fire) rx_show = 0;
      tx_taken = 0; rx_taken = 0;
      if (gpu_valid_in) begin
        if (!tx_valid_id(gpu_data_in)) begin
          tx_taken = 1; if (m_drop_tx < 255) m_drop_tx++;
        end else if (!tx_full) begin
          tx_taken = 1; txq.push_back(rewrite(gpu_data_in, OFS));
        end
      end
      if (router_valid_in) begin
        if (int'(router_data_in[DW-1 -: HW]) != ID + OFS) begin
          rx_taken = 1; if (m_drop_rx < 255) m_drop_rx++;
        end else if (!rx_full) begin
          rx_taken = 1; rxq.push_back(rewrite(router_data_in, -OFS));
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("router_valid_out", router_valid_out, tx_show);
      if (tx_show) chk("router_data_out", router_data_out, tx_sd);
      chk("gpu_valid_out", gpu_valid_out, rx_show);
      if (rx_show) chk("gpu_data_out", gpu_data_out, rx_sd);
      chk("gpu_ready_out", gpu_ready_out, txq.size() < DEPTH);
      chk("router_ready_out", router_ready_out, rxq.size() < DEPTH);
      chk("drop_cnt_tx", drop_cnt_tx, m_drop_tx);
      chk("drop_cnt_rx", drop_cnt_rx, m_drop_rx);
    end
  end

  // Stability while stalled, checked independently of the model.
  logic [DW-1:0] prev_gd; logic prev_stall = 0;
  always @(negedge clk) begin
    if (reset_n && prev_stall) begin
      chk("gpu_out_stable_valid", gpu_valid_out, 1'b1);
      chk("gpu_out_stable_data", gpu_data_out, prev_gd);
    end
    prev_stall = reset_n && gpu_valid_out && !gpu_ready_in;
    prev_gd = gpu_data_out;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    gpu_valid_in = 0; router_valid_in = 0;
  endtask

  // Assert reset mid-phase; outputs must clear without waiting for an edge.
  task automatic do_reset();
    #2 reset_n = 0;
    #1;
    chk("rst_router_valid", router_valid_out, 0);
    chk("rst_router_data", router_data_out, 0);
    chk("rst_gpu_valid", gpu_valid_out, 0);
    chk("rst_gpu_data", gpu_data_out, 0);
    chk("rst_drop_tx", drop_cnt_tx, 0);
    chk("rst_drop_rx", drop_cnt_rx, 0);
    chk("rst_gpu_ready", gpu_ready_out, 1);
    chk("rst_router_ready", router_ready_out, 1);
    idle();
    cyc(2);
    reset_n = 1;
  endtask

  initial begin
    cyc(1);
    do_reset();

    // Basic TX latency: 0x2C05 -> 0x3805 after the second edge.
    router_ready_in = 1; gpu_ready_in = 1;
    gpu_data_in = 16'h2C05; gpu_valid_in = 1;
    cyc(1); gpu_valid_in = 0;
    chk("lat_not_yet", router_valid_out, 0);
    cyc(1);
    chk("lat_valid", router_valid_out, 1);
    chk("lat_data", router_data_out, 16'h3805);
    cyc(2);

    // Backpressure: FIFO plus output stage absorb 9 flits.
    do_reset();
    router_ready_in = 0;
    for (int i = 0; i < 9; i++) begin
      gpu_data_in = 16'h2C00 | 16'(i); gpu_valid_in = 1;
      cyc(1);
      if (i == 7) chk("bp_ready_after8", gpu_ready_out, 1);
    end
    chk("bp_ready_low", gpu_ready_out, 0);
    gpu_data_in = 16'h2C09;
    cyc(3);
    chk("bp_held", gpu_ready_out, 0);
    chk("bp_head", router_data_out, 16'h3800);
    router_ready_in = 1; cyc(1); router_ready_in = 0;
    chk("bp_ready_back", gpu_ready_out, 1);
    gpu_valid_in = 0;
    router_ready_in = 1; cyc(14);

    // RX rewrite and address filtering.
    do_reset();
    gpu_ready_in = 1;
    router_data_in = 16'h3801; router_valid_in = 1;
    cyc(1); router_data_in = 16'h3C01;
    cyc(1); router_valid_in = 0;
    chk("rx_data", gpu_data_out, 16'h2C01);
    chk("rx_valid", gpu_valid_out, 1);
    cyc(2);
    chk("rx_drop", drop_cnt_rx, 1);
    chk("rx_no_more", gpu_valid_out, 0);

    // TX invalid IDs and counter saturation.
    do_reset();
    gpu_data_in = 16'h0005; gpu_valid_in = 1; cyc(1);
    gpu_data_in = 16'hA000; cyc(1); gpu_valid_in = 0;
    cyc(2);
    chk("tx_drop2", drop_cnt_tx, 2);
    chk("tx_nothing", router_valid_out, 0);
    gpu_data_in = 16'h0000; gpu_valid_in = 1; cyc(298); gpu_valid_in = 0;
    cyc(1);
    chk("tx_sat", drop_cnt_tx, 255);

    // Reset with flits buffered: nothing stale afterwards.
    do_reset();
    router_ready_in = 0; gpu_ready_in = 0;
    for (int i = 0; i < 5; i++) begin
      gpu_data_in = 16'h0400 | 16'(i); gpu_valid_in = 1;
      router_data_in = 16'h3810 | 16'(i); router_valid_in = 1;
      cyc(1);
    end
    do_reset();
    router_ready_in = 1; gpu_ready_in = 1;
    cyc(4);
    chk("post_rst_tx_quiet", router_valid_out, 0);
    chk("post_rst_rx_quiet", gpu_valid_out, 0);

    // Randomized streaming with random backpressure on both sides.
    for (int c = 0; c < 1500; c++) begin
      gpu_ready_in = ($urandom_range(0, 2) != 0);
      router_ready_in = ($urandom_range(0, 3) != 0);
      if (!gpu_valid_in || tx_taken) begin
        gpu_valid_in = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) gpu_data_in = {6'(($urandom_range(0, 1) != 0) ? 0 : $urandom_range(33, 63)), 10'($urandom)};
        else gpu_data_in = {6'($urandom_range(1, NG)), 10'($urandom)};
      end
      if (!router_valid_in || rx_taken) begin
        router_valid_in = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) router_data_in = {6'($urandom_range(15, 63)), 10'($urandom)};
        else router_data_in = {6'(ID + OFS), 10'($urandom)};
      end
      cyc(1);
    end
    idle(); gpu_ready_in = 1; router_ready_in = 1;
    cyc(20);
    chk("drain_tx", router_valid_out, 0);
    chk("drain_rx", gpu_valid_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
